// File: rtl/axi_channel_pkg.sv
// Shared types and elaboration helpers for the AXI channel register FIFO.
package axi_channel_pkg;

    typedef enum logic {
        HS_REGISTERED = 1'b0,
        HS_FALLTHRU   = 1'b1
    } hndshk_mode_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit afull_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/axi_channel_fifo_ctrl.sv
// Pointer, occupancy, enable and almost-full bookkeeping for axi_channel_reg_fifo.
module axi_channel_fifo_ctrl
    import axi_channel_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int AFULL_THRESH = DEPTH - 1,
    localparam int PW           = $clog2(DEPTH),
    localparam int CW           = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic          i_rd,
    output logic [PW-1:0] o_wptr,
    output logic [PW-1:0] o_rptr,
    output logic [CW-1:0] o_count,
    output logic          o_enable,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_almost_full
);

    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (!afull_ok(AFULL_THRESH, DEPTH)) begin : g_bad_afull
        $error("AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_en_pre;
    logic          r_enable;
    logic          r_afull;

    always_comb begin
        w_count_nxt = r_count;
        case ({i_wr, i_rd})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Two-stage enable so the source sees ready only from the second cycle after release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_en_pre <= 1'b0;
            r_enable <= 1'b0;
            r_afull  <= 1'b0;
        end else begin
            r_en_pre <= 1'b1;
            r_enable <= r_en_pre;
            if (i_wr) r_wptr <= r_wptr + PW'(1);
            if (i_rd) r_rptr <= r_rptr + PW'(1);
            r_count  <= w_count_nxt;
            r_afull  <= (w_count_nxt >= AFULL_C);
        end
    end

    assign o_wptr        = r_wptr;
    assign o_rptr        = r_rptr;
    assign o_count       = r_count;
    assign o_enable      = r_enable;
    assign o_full        = (r_count == FULL_C);
    assign o_empty       = (r_count == '0);
    assign o_almost_full = r_afull;

endmodule

// File: rtl/axi_channel_reg_fifo.sv
// Valid/ready buffer for any AXI channel: registered or fall-through handshake.
// Optional stats ports (high_water, stall_cnt) under `AXI_CHANNEL_FIFO_STATS_EN.
module axi_channel_reg_fifo
    import axi_channel_pkg::*;
#(
    parameter int           PAYLD_WIDTH  = 82,
    parameter int           DEPTH        = 4,
    parameter hndshk_mode_e HNDSHK_MODE  = HS_REGISTERED,
    parameter int           AFULL_THRESH = DEPTH - 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        valid_src,
    input  logic [PAYLD_WIDTH-1:0]      payload_src,
    output logic                        ready_src,
    output logic                        valid_dst,
    output logic [PAYLD_WIDTH-1:0]      payload_dst,
    input  logic                        ready_dst,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        almost_full
`ifdef AXI_CHANNEL_FIFO_STATS_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]     high_water,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PAYLD_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]          w_wptr;
    logic [PW-1:0]          w_rptr;
    logic [CW-1:0]          w_count;
    logic                   w_enable;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_rd;

    axi_channel_fifo_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ctrl (
        .i_clk         (aclk),
        .i_rst         (areset),
        .i_wr          (w_wr),
        .i_rd          (w_rd),
        .o_wptr        (w_wptr),
        .o_rptr        (w_rptr),
        .o_count       (w_count),
        .o_enable      (w_enable),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_almost_full (almost_full)
    );

    assign ready_src = w_enable && !w_full;
    assign w_push    = valid_src && ready_src;
    assign w_pop     = valid_dst && ready_dst;
    // A beat taken straight through while empty is never stored.
    assign w_wr      = w_push && !(w_empty && w_pop);
    assign w_rd      = w_pop && !w_empty;
    assign count     = w_count;

    if (HNDSHK_MODE == HS_FALLTHRU) begin : g_fallthru
        assign valid_dst   = w_empty ? (valid_src && w_enable) : 1'b1;
        assign payload_dst = w_empty ? payload_src : r_mem[w_rptr];
    end else begin : g_registered
        assign valid_dst   = !w_empty;
        assign payload_dst = r_mem[w_rptr];
    end

    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[w_wptr] <= payload_src;
    end

`ifdef AXI_CHANNEL_FIFO_STATS_EN
    logic [CW-1:0] r_high_water;
    logic [31:0]   r_stall_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_high_water <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_count > r_high_water) r_high_water <= w_count;
            if (valid_dst && !ready_dst && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign high_water = r_high_water;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_axi_channel_reg_fifo.sv
// Directed bench: one registered-mode and one fall-through-mode instance.
module tb_axi_channel_reg_fifo;
    import axi_channel_pkg::*;

    localparam int W  = 82;
    localparam int D  = 4;
    localparam int CW = cnt_w(D);

    logic          clk = 1'b0;
    logic          areset;
    logic          v0, r0, v1, r1;
    logic [W-1:0]  p0, p1;
    logic          rs0, vd0, af0, rs1, vd1, af1;
    logic [W-1:0]  pd0, pd1;
    logic [CW-1:0] c0, c1;
`ifdef AXI_CHANNEL_FIFO_STATS_EN
    logic [CW-1:0] hw0, hw1;
    logic [31:0]   sc0, sc1;
`endif

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi_channel_reg_fifo #(
        .PAYLD_WIDTH  (W),
        .DEPTH        (D),
        .HNDSHK_MODE  (HS_REGISTERED),
        .AFULL_THRESH (3)
    ) u_dut0 (
        .aclk        (clk),
        .areset      (areset),
        .valid_src   (v0),
        .payload_src (p0),
        .ready_src   (rs0),
        .valid_dst   (vd0),
        .payload_dst (pd0),
        .ready_dst   (r0),
        .count       (c0),
        .almost_full (af0)
`ifdef AXI_CHANNEL_FIFO_STATS_EN
        ,
        .high_water  (hw0),
        .stall_cnt   (sc0)
`endif
    );

    axi_channel_reg_fifo #(
        .PAYLD_WIDTH  (W),
        .DEPTH        (D),
        .HNDSHK_MODE  (HS_FALLTHRU),
        .AFULL_THRESH (3)
    ) u_dut1 (
        .aclk        (clk),
        .areset      (areset),
        .valid_src   (v1),
        .payload_src (p1),
        .ready_src   (rs1),
        .valid_dst   (vd1),
        .payload_dst (pd1),
        .ready_dst   (r1),
        .count       (c1),
        .almost_full (af1)
`ifdef AXI_CHANNEL_FIFO_STATS_EN
        ,
        .high_water  (hw1),
        .stall_cnt   (sc1)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        areset = 1'b1;
        v0 = 1'b0; r0 = 1'b0; p0 = '0;
        v1 = 1'b0; r1 = 1'b0; p1 = '0;
        tick();
        tick();

        // Step 1: release and first beat on both instances
        areset = 1'b0;
        v0 = 1'b1; p0 = W'(1);
        v1 = 1'b1; p1 = W'(1);
        #1;
        chk("rst_count0", W'(c0), W'(0));
        chk("rst_valid0", W'(vd0), W'(0));
        chk("rst_afull0", W'(af0), W'(0));
        chk("c0_ready0", W'(rs0), W'(0));
        chk("c0_valid1", W'(vd1), W'(0));
        tick();
        chk("c1_ready0", W'(rs0), W'(0));
        chk("c1_ready1", W'(rs1), W'(0));
        tick();
        chk("c2_ready0", W'(rs0), W'(1));
        chk("c2_valid0", W'(vd0), W'(0));
        chk("c2_valid1", W'(vd1), W'(1));
        chk("c2_pay1", pd1, W'(1));
        tick();
        chk("c3_valid0", W'(vd0), W'(1));
        chk("c3_pay0", pd0, W'(1));
        chk("c3_count0", W'(c0), W'(1));
        chk("c3_count1", W'(c1), W'(1));
        chk("c3_pay1", pd1, W'(1));
        v0 = 1'b0; r0 = 1'b1;
        v1 = 1'b0; r1 = 1'b1;
        tick();
        chk("drain_count0", W'(c0), W'(0));
        chk("drain_count1", W'(c1), W'(0));
        r0 = 1'b0; r1 = 1'b0;

        // Step 2: fill to full, fifth beat held off
        v0 = 1'b1; p0 = W'('hA);
        tick();
        chk("fill1_count", W'(c0), W'(1));
        chk("fill1_afull", W'(af0), W'(0));
        p0 = W'('hB);
        tick();
        chk("fill2_count", W'(c0), W'(2));
        chk("fill2_afull", W'(af0), W'(0));
        p0 = W'('hC);
        tick();
        chk("fill3_count", W'(c0), W'(3));
        chk("fill3_afull", W'(af0), W'(1));
        chk("fill3_ready", W'(rs0), W'(1));
        p0 = W'('hD);
        tick();
        chk("fill4_count", W'(c0), W'(4));
        chk("fill4_afull", W'(af0), W'(1));
        chk("fill4_ready", W'(rs0), W'(0));
        p0 = W'('hE);
        tick();
        chk("full_hold_count", W'(c0), W'(4));
        chk("full_hold_ready", W'(rs0), W'(0));
        chk("full_head", pd0, W'('hA));

        // Step 3: single pop from full, then refill and drain in order
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        chk("pop_count", W'(c0), W'(3));
        chk("pop_head", pd0, W'('hB));
        chk("pop_ready", W'(rs0), W'(1));
        chk("pop_afull", W'(af0), W'(1));
        tick();
        chk("refill_count", W'(c0), W'(4));
        v0 = 1'b0; r0 = 1'b1;
        chk("out_B", pd0, W'('hB));
        tick();
        chk("out_C", pd0, W'('hC));
        tick();
        chk("out_D", pd0, W'('hD));
        tick();
        chk("out_E", pd0, W'('hE));
        tick();
        chk("empty_count", W'(c0), W'(0));
        chk("empty_valid", W'(vd0), W'(0));
        chk("empty_afull", W'(af0), W'(0));
        r0 = 1'b0;

        // Step 4: streaming at occupancy 2 across pointer wraps
        v0 = 1'b1; p0 = W'(100);
        tick();
        p0 = W'(101);
        tick();
        r0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p0 = W'(i);
            #1;
            chk("stream_count", W'(c0), W'(2));
            chk("stream_data", pd0, (i == 0) ? W'(100) : (i == 1) ? W'(101) : W'(i - 2));
            tick();
        end
        v0 = 1'b0;
        chk("tail_18", pd0, W'(18));
        tick();
        chk("tail_19", pd0, W'(19));
        tick();
        chk("tail_count", W'(c0), W'(0));
        r0 = 1'b0;

        // Step 5: fall-through bypass, then stored when sink stalls
        v1 = 1'b1; p1 = W'('h3FF); r1 = 1'b1;
        #1;
        chk("byp_valid", W'(vd1), W'(1));
        chk("byp_pay", pd1, W'('h3FF));
        tick();
        chk("byp_count", W'(c1), W'(0));
        r1 = 1'b0;
        #1;
        chk("stall_valid", W'(vd1), W'(1));
        tick();
        v1 = 1'b0; p1 = W'('h155);
        #1;
        chk("stored_count", W'(c1), W'(1));
        chk("stored_pay", pd1, W'('h3FF));
        chk("stored_valid", W'(vd1), W'(1));
        r1 = 1'b1;
        tick();
        chk("ft_drain_count", W'(c1), W'(0));
        chk("ft_drain_valid", W'(vd1), W'(0));
        r1 = 1'b0;

        // Step 6: reset with three beats stored
        v0 = 1'b1;
        p0 = W'('h21); tick();
        p0 = W'('h22); tick();
        p0 = W'('h23); tick();
        v0 = 1'b0;
        chk("pre_rst_count", W'(c0), W'(3));
        chk("pre_rst_afull", W'(af0), W'(1));
`ifdef AXI_CHANNEL_FIFO_STATS_EN
        chk("pre_rst_hw", W'(hw0), W'(4));
`endif
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        chk("mid_rst_count", W'(c0), W'(0));
        chk("mid_rst_valid", W'(vd0), W'(0));
        chk("mid_rst_ready", W'(rs0), W'(0));
        chk("mid_rst_afull", W'(af0), W'(0));
`ifdef AXI_CHANNEL_FIFO_STATS_EN
        chk("mid_rst_hw", W'(hw0), W'(0));
        chk("mid_rst_stall", W'(sc0), W'(0));
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/axi_channel_reg_fifo.md
Name: axi_channel_reg_fifo

Overview:
Parametrised successor to the two-entry AXI channel register slice. It is a valid/ready buffer with configurable payload width and depth, and two handshake modes: registered, and fall-through bypass. It also exposes an occupancy count and an almost-full flag. It sits on any AXI channel (AW/W/AR/R/B) between masters and the interconnect, to break timing paths and absorb bursts.

Parameters:
- PAYLD_WIDTH, 82, payload bits per beat (>=1).
- DEPTH, 4, number of storage entries (power of 2, >=2).
- HNDSHK_MODE, 0.
  - 0 = registered output, 1-cycle min latency, no src->dst combinational path.
  - 1 = fall-through when empty, 0-cycle latency.
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH (1..DEPTH).

Ports:
- aclk  in  1  clock; all state on rising edge.
- areset  in  1  reset.
- valid_src  in  1  source beat valid.
- payload_src  in  PAYLD_WIDTH  source beat data.
- ready_src  out  1  buffer can accept a beat.
- valid_dst  out  1  beat available to sink.
- payload_dst  out  PAYLD_WIDTH  sink beat data.
- ready_dst  in  1  sink accepts beat.
- count  out  $clog2(DEPTH+1)  stored entries (bypassed beats are not counted).
- almost_full  out  1  count >= AFULL_THRESH, registered.

Interface rules:
- One clock; reset is synchronous and active-high.
- Clock port is aclk; reset port is areset.

Behaviour:
- Reset (areset=1 at a rising edge) sets:
  - wptr=0, rptr=0, count=0.
  - ready_src=0, valid_dst=0, almost_full=0, enable=0.
  - payload_dst is don't-care (storage is not reset).
- ready_src = enable && !full.
  - enable goes to 1 one cycle after areset deasserts, so ready_src is first high in the second cycle after reset release.
  - ready_src never depends combinationally on ready_dst or valid_src.
- Push = valid_src && ready_src. Pop = valid_dst && ready_dst.
- Mode 0:
  - valid_dst = (count != 0).
  - payload_dst = mem[rptr].
  - A push into an empty buffer is visible at valid_dst on the next cycle.
- Mode 1:
  - When count==0: valid_dst = valid_src && enable, and payload_dst = payload_src.
  - If the sink takes that beat in the same cycle, it is not written and count is unchanged.
  - Otherwise the beat is written and count goes to 1.
  - When count>0, behaviour is identical to mode 0.
- Push with no pop: mem[wptr] <= payload_src, wptr++, count++.
- Pop with no push: rptr++, count--.
- Simultaneous push and pop with count>0: write and read both advance and count is unchanged. This includes count==DEPTH-1.
- Full (count==DEPTH): ready_src=0.
  - A pop in the full cycle frees an entry; ready_src rises on the next cycle.
  - There is no same-cycle refill.
- Empty: a pop cannot occur, because valid_dst=0 in mode 0. The mode 1 bypass is handled as above.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count saturates only logically, since push is blocked when full.
- almost_full is registered from next-count and is valid in the same cycle as count.
- areset asserted mid-operation discards all stored beats; the outputs above apply from the next cycle.
- valid_src dropping without a handshake is legal input. Held payload is never corrupted: storage writes only on push.

Optional Feature:
- Macro: AXI_CHANNEL_FIFO_STATS_EN.
- Defined:
  - Adds output high_water [$clog2(DEPTH+1)-1:0], the maximum count seen since reset (cleared by areset, updated the cycle after count rises).
  - Adds output stall_cnt [31:0], which increments every cycle with valid_dst && !ready_dst. It saturates at 32'hFFFFFFFF and is cleared by areset.
- Undefined: neither port nor its logic exists; the rest of the block is unchanged.

Decomposition:
- Package axi_channel_pkg contains:
  - Enum hndshk_mode_e {HS_REGISTERED=0, HS_FALLTHRU=1}.
  - Function cnt_w(depth) returning $clog2(depth+1).
  - Localparam check helpers: DEPTH power-of-2 assertion, AFULL_THRESH range assertion.
- Sub-module axi_channel_fifo_ctrl holds pointers, count, enable, full/empty and almost_full.
- Top level holds storage, the bypass mux and the optional stats.

Test Plan (PAYLD_WIDTH=82, DEPTH=4, AFULL_THRESH=3):
1. Reset release, then valid_src=1 held -> ready_src=0 for cycles 0-1 after release and 1 from cycle 2. The first beat (0x1) appears on valid_dst the next cycle in mode 0, or the same cycle in mode 1.
2. Push 0xA,0xB,0xC,0xD with ready_dst=0 -> count 1,2,3,4; almost_full high at count 3; ready_src=0 at count 4. A fifth beat 0xE is held on src and not accepted.
3. From full, ready_dst=1 for one cycle -> 0xA popped, count=3. ready_src rises next cycle; 0xE accepted; order out is B,C,D,E.
4. Continuous push and pop at count=2 for 20 cycles, payload = cycle index -> count stays 2, outputs strictly in order, pointers wrap 5 times without loss.
5. Mode 1 with empty buffer, valid_src=1, ready_dst=1, payload 0x3FF -> payload_dst=0x3FF the same cycle, count stays 0. With ready_dst=0 the beat is stored, count=1, and the same payload is held.
6. areset pulsed while count=3 -> next cycle count=0, valid_dst=0, ready_src=0, almost_full=0. With STATS_EN, high_water=0 and stall_cnt=0.
